aes_bram_port: RTL

//  Word-access BRAM port controller serving the AES engine's read/write request handshake.
//  It converts level start_read/start_write requests plus a byte address into timed BRAM port

---
 rtl/aes_bram_port_if.sv | 41 ++++
 rtl/aes_bram_port.sv | 127 ++++++++++++
 2 files changed

// File: rtl/aes_bram_port_if.sv
// Request/response bus between the AES engine and the BRAM port controller,
// plus the BRAM port pins the controller drives.
//
// Handshake: the master raises req_rd or req_wr (level) with req_addr and
// req_wdata stable. The slave answers with bram_complete and keeps it high
// until the master has dropped both requests. A request still high while
// bram_complete is high is never serviced a second time. rsp_rdata is
// meaningful while bram_complete is high after a read.
//
// The master modport is the environment side: the engine and the BRAM
// together.
interface aes_bram_port_if #(
  parameter int BRAM_AW = 11
);
  logic               req_rd;
  logic               req_wr;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [31:0]        rsp_rdata;
  logic               bram_complete;
  logic               err_range;
  logic               err_conflict;
  logic [15:0]        acc_count;
  logic               bram_en;
  logic [3:0]         bram_we;
  logic [BRAM_AW-1:0] bram_addr;
  logic [31:0]        bram_din;
  logic [31:0]        bram_dout;

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, bram_dout,
    output rsp_rdata, bram_complete, err_range, err_conflict, acc_count,
           bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, bram_dout,
    input  rsp_rdata, bram_complete, err_range, err_conflict, acc_count,
           bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/aes_bram_port.sv
// Word-access BRAM port controller for the AES engine. It turns level read
// and write requests into single BRAM port cycles, waits out the BRAM read
// latency, and acknowledges with bram_complete. Addresses outside the window
// or not word-aligned never reach the BRAM.
module aes_bram_port #(
  parameter int          RD_LAT     = 2,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1FFC,
  parameter int          BRAM_AW    = 11
) (
  input  logic             aes_clk,
  input  logic             aes_rst_n,
  aes_bram_port_if.slave   bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         lat_cnt;
  logic [BRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;

  // 33-bit subtraction: bit 32 flags an address below the window without a
  // constant comparison against a zero base.
  logic [32:0]        offset;
  logic               addr_bad;
  logic               any_req;
  logic               conflict;
  logic               acc_done;

  assign offset   = {1'b0, bus.req_addr} - {1'b0, ADDR_BASE};
  assign addr_bad = (bus.req_addr[1:0] != 2'b00) || offset[32] ||
                    (bus.req_addr > ADDR_LIMIT);
  assign any_req  = bus.req_rd | bus.req_wr;
  assign conflict = bus.req_rd & bus.req_wr;
  // A legal access enters ACK from RD_WAIT (counter expired) or WR_ISSUE.
  assign acc_done = ((state == RD_WAIT) && (lat_cnt == 2'd0)) ||
                    (state == WR_ISSUE);

  // State register, returned to IDLE asynchronously on reset.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode; conflicts and bad addresses go straight to ACK.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (conflict)                state_nxt = ACK;
        else if (any_req && addr_bad) state_nxt = ACK;
        else if (bus.req_rd)         state_nxt = RD_ISSUE;
        else if (bus.req_wr)         state_nxt = WR_ISSUE;
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_cnt == 2'd0) state_nxt = ACK;
      WR_ISSUE: state_nxt = ACK;
      ACK:      if (!any_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: BRAM strobes only in the issue states.
  always_comb begin
    bus.bram_en       = 1'b0;
    bus.bram_we       = 4'h0;
    bus.bram_complete = 1'b0;
    dbg_state         = state;
    case (state)
      RD_ISSUE: bus.bram_en = 1'b1;
      WR_ISSUE: begin
        bus.bram_en = 1'b1;
        bus.bram_we = 4'hF;
      end
      ACK:      bus.bram_complete = 1'b1;
      default:  ;
    endcase
  end

  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = wdata_q;

  // Datapath: request capture, latency count, read data, errors, counter.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      lat_cnt          <= 2'd0;
      addr_q           <= '0;
      wdata_q          <= 32'h0;
      bus.rsp_rdata    <= 32'h0;
      bus.err_range    <= 1'b0;
      bus.err_conflict <= 1'b0;
      bus.acc_count    <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (conflict) begin
            bus.err_conflict <= 1'b1;
            bus.rsp_rdata    <= 32'h0;
          end else if (any_req && addr_bad) begin
            bus.err_range <= 1'b1;
            bus.rsp_rdata <= 32'h0;
          end else if (any_req) begin
            addr_q  <= offset[BRAM_AW+1:2];
            wdata_q <= bus.req_wdata;
          end
        end
        RD_ISSUE: lat_cnt <= 2'(RD_LAT - 1);
        RD_WAIT: begin
          if (lat_cnt == 2'd0) bus.rsp_rdata <= bus.bram_dout;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
        default: ;
      endcase
      if (acc_done) bus.acc_count <= bus.acc_count + 16'd1;
    end
  end

endmodule
